pipe_ctrl: RTL and testbench

Pipeline control unit for the rv32i core: the producer side of the hold/flush protocol that the IF/ID and ID/EX pipeline registers consume. It arbitrates stall requests from the execute stage, the bus interconnect, the CLINT and the debug halt line, then drives a single encoded `hold_flag_o` plus the jump redirect to the PC register. Its sequential logic covers the post-jump flush window, debug-halt sequencing and a stall watchdog with a stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_stall_wdt.sv | 52 +++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, hold-level encoding and state encoding for the pipeline control unit.
package pipe_ctrl_pkg;

   localparam int unsigned InstAddrW = 32;
   localparam int unsigned HoldFlagW = 3;
   localparam int unsigned FlushCntW = 3;
   localparam int unsigned StallCntW = 32;

   typedef logic [InstAddrW-1:0] inst_addr_t;

   // A stage stalls when the broadcast hold level is >= its own level.
   typedef enum logic [HoldFlagW-1:0] {
      HOLD_NONE = 3'd0,
      HOLD_PC   = 3'd1,
      HOLD_IF   = 3'd2,
      HOLD_ID   = 3'd3
   } hold_flag_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } ctrl_state_e;

   // Redirect payload sent to the PC register.
   typedef struct packed {
      logic       valid;
      inst_addr_t addr;
   } redirect_t;

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall watchdog: consecutive-stall counter, sticky timeout flag and saturating stall-cycle count.
module stall_wdt
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned STALL_LIMIT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 halt_i,
   input  logic                 timeout_clr_i,
   output logic                 stall_timeout_o,
   output logic [StallCntW-1:0] stall_cycles_o
);

   localparam int unsigned WdtW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [WdtW-1:0] WdtMax = WdtW'(STALL_LIMIT - 1);

   logic [WdtW-1:0] wdt_cnt;
   logic            timeout_set;

   // Halt cycles are a deliberate park, so they neither advance nor trip the watchdog.
   always_comb begin
      timeout_set = stall_i && !halt_i && (wdt_cnt == WdtMax);
   end

   // Counters and sticky flag; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdt_cnt         <= '0;
         stall_timeout_o <= 1'b0;
         stall_cycles_o  <= '0;
      end else begin
         if (!stall_i) begin
            wdt_cnt <= '0;
         end else if (!halt_i && (wdt_cnt != WdtMax)) begin
            wdt_cnt <= wdt_cnt + WdtW'(1);
         end

         if (timeout_set) begin
            stall_timeout_o <= 1'b1;
         end else if (timeout_clr_i) begin
            stall_timeout_o <= 1'b0;
         end

         if (stall_i && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + StallCntW'(1);
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates stall sources into one hold level, drives the jump redirect,
// and sequences the post-jump flush window and debug halt.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned STALL_LIMIT  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 jump_flag_i,
   input  logic [InstAddrW-1:0] jump_addr_i,
   input  logic                 hold_flag_ex_i,
   input  logic                 hold_flag_rib_i,
   input  logic                 int_assert_i,
   input  logic                 halt_req_i,
   input  logic                 timeout_clr_i,
   output logic [HoldFlagW-1:0] hold_flag_o,
   output logic                 jump_flag_o,
   output logic [InstAddrW-1:0] jump_addr_o,
   output logic                 halted_o,
   output logic                 stall_timeout_o,
   output logic [StallCntW-1:0] stall_cycles_o
);

   localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES);

   ctrl_state_e          state, state_d;
   logic [FlushCntW-1:0] flush_cnt, flush_cnt_d;
   hold_flag_e           hold;
   redirect_t            redir;
   logic                 halt_act;
   logic                 halt_enter;

   // State register and flush counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
      end else begin
         state     <= state_d;
         flush_cnt <= flush_cnt_d;
      end
   end

   // Hold arbitration, redirect and next-state logic.
   always_comb begin
      hold        = HOLD_NONE;
      redir       = '0;
      state_d     = state;
      flush_cnt_d = flush_cnt;

      // An interrupt entry in flight is never cut short by a new halt request.
      halt_enter = halt_req_i && !int_assert_i;
      halt_act   = (state == ST_HALT) || halt_enter;

      if (halt_act) begin
         hold = HOLD_ID;
      end else if (int_assert_i) begin
         hold        = HOLD_ID;
         redir.valid = jump_flag_i;
         redir.addr  = jump_flag_i ? jump_addr_i : '0;
      end else if (jump_flag_i) begin
         hold        = HOLD_ID;
         redir.valid = 1'b1;
         redir.addr  = jump_addr_i;
      end else if (hold_flag_ex_i) begin
         hold = HOLD_ID;
      end else if (hold_flag_rib_i) begin
         hold = HOLD_PC;
      end else if (state == ST_FLUSH) begin
         hold = HOLD_ID;
      end

      if (halt_enter) begin
         state_d     = ST_HALT;
         flush_cnt_d = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (redir.valid && (FLUSH_CYCLES != 0)) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FlushLoad;
               end
            end
            ST_FLUSH: begin
               if (redir.valid) begin
                  flush_cnt_d = FlushLoad;
               end else if (flush_cnt <= FlushCntW'(1)) begin
                  state_d     = ST_IDLE;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt - FlushCntW'(1);
               end
            end
            ST_HALT: begin
               if (!halt_req_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               flush_cnt_d = '0;
            end
         endcase
      end
   end

   // Zero-latency hold and redirect outputs.
   always_comb begin
      hold_flag_o = hold;
      jump_flag_o = redir.valid;
      jump_addr_o = redir.addr;
   end

   // Halt status lags the state decision by one cycle.
   always_comb begin
      halted_o = (state == ST_HALT);
   end

   stall_wdt #(
      .STALL_LIMIT(STALL_LIMIT)
   ) u_stall_wdt (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (hold != HOLD_NONE),
      .halt_i         (halt_act),
      .timeout_clr_i  (timeout_clr_i),
      .stall_timeout_o(stall_timeout_o),
      .stall_cycles_o (stall_cycles_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=2 and STALL_LIMIT=16.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 jump_flag_i = 1'b0;
   logic [InstAddrW-1:0] jump_addr_i = '0;
   logic                 hold_flag_ex_i = 1'b0;
   logic                 hold_flag_rib_i = 1'b0;
   logic                 int_assert_i = 1'b0;
   logic                 halt_req_i = 1'b0;
   logic                 timeout_clr_i = 1'b0;
   logic [HoldFlagW-1:0] hold_flag_o;
   logic                 jump_flag_o;
   logic [InstAddrW-1:0] jump_addr_o;
   logic                 halted_o;
   logic                 stall_timeout_o;
   logic [StallCntW-1:0] stall_cycles_o;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl #(
      .FLUSH_CYCLES(2),
      .STALL_LIMIT (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .jump_flag_i    (jump_flag_i),
      .jump_addr_i    (jump_addr_i),
      .hold_flag_ex_i (hold_flag_ex_i),
      .hold_flag_rib_i(hold_flag_rib_i),
      .int_assert_i   (int_assert_i),
      .halt_req_i     (halt_req_i),
      .timeout_clr_i  (timeout_clr_i),
      .hold_flag_o    (hold_flag_o),
      .jump_flag_o    (jump_flag_o),
      .jump_addr_o    (jump_addr_o),
      .halted_o       (halted_o),
      .stall_timeout_o(stall_timeout_o),
      .stall_cycles_o (stall_cycles_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
   task automatic drive(input logic jf, input logic [31:0] ja, input logic ex, input logic rib,
                        input logic intr, input logic halt, input logic clr);
      @(negedge clk);
      jump_flag_i     = jf;
      jump_addr_i     = ja;
      hold_flag_ex_i  = ex;
      hold_flag_rib_i = rib;
      int_assert_i    = intr;
      halt_req_i      = halt;
      timeout_clr_i   = clr;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_hold", 32'(hold_flag_o), 32'd0);
      chk("rst_jf", 32'(jump_flag_o), 32'd0);
      chk("rst_ja", jump_addr_o, 32'd0);
      chk("rst_halted", 32'(halted_o), 32'd0);
      chk("rst_to", 32'(stall_timeout_o), 32'd0);
      chk("rst_sc", stall_cycles_o, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         idle();
         chk("idle_hold", 32'(hold_flag_o), 32'd0);
         chk("idle_jf", 32'(jump_flag_o), 32'd0);
      end
      chk("idle_sc", stall_cycles_o, 32'd0);

      // Jump flush: 3 cycles of Hold_Id
      drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jmp_jf", 32'(jump_flag_o), 32'd1);
      chk("jmp_ja", jump_addr_o, 32'h80);
      chk("jmp_hold0", 32'(hold_flag_o), 32'd3);
      idle();
      chk("jmp_hold1", 32'(hold_flag_o), 32'd3);
      chk("jmp_jf1", 32'(jump_flag_o), 32'd0);
      chk("jmp_ja1", jump_addr_o, 32'd0);
      idle();
      chk("jmp_hold2", 32'(hold_flag_o), 32'd3);
      idle();
      chk("jmp_hold3", 32'(hold_flag_o), 32'd0);
      chk("jmp_sc", stall_cycles_o, 32'd3);

      // Second jump mid-flush restarts the window
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rj_hold0", 32'(hold_flag_o), 32'd3);
      idle();
      chk("rj_hold1", 32'(hold_flag_o), 32'd3);
      drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rj_jf", 32'(jump_flag_o), 32'd1);
      chk("rj_ja", jump_addr_o, 32'h200);
      chk("rj_hold2", 32'(hold_flag_o), 32'd3);
      idle();
      chk("rj_hold3", 32'(hold_flag_o), 32'd3);
      idle();
      chk("rj_hold4", 32'(hold_flag_o), 32'd3);
      idle();
      chk("rj_hold5", 32'(hold_flag_o), 32'd0);
      chk("rj_sc", stall_cycles_o, 32'd8);

      // Priority: jump beats bus stall; bus stall alone gives Hold_Pc
      drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pri_hold", 32'(hold_flag_o), 32'd3);
      chk("pri_jf", 32'(jump_flag_o), 32'd1);
      chk("pri_ja", jump_addr_o, 32'h44);
      idle();
      chk("pri_fl1", 32'(hold_flag_o), 32'd3);
      idle();
      chk("pri_fl2", 32'(hold_flag_o), 32'd3);
      idle();
      chk("pri_fl3", 32'(hold_flag_o), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rib_hold", 32'(hold_flag_o), 32'd1);
      chk("rib_jf", 32'(jump_flag_o), 32'd0);
      idle();
      chk("rib_off", 32'(hold_flag_o), 32'd0);
      chk("pri_sc", stall_cycles_o, 32'd12);

      // Interrupt with halt request: jump lines pass through, no HALT
      drive(1'b1, 32'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("ih_jf", 32'(jump_flag_o), 32'd1);
      chk("ih_ja", jump_addr_o, 32'h1C);
      chk("ih_hold", 32'(hold_flag_o), 32'd3);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("ih_jf0", 32'(jump_flag_o), 32'd0);
      chk("ih_ja0", jump_addr_o, 32'd0);
      chk("ih_hold1", 32'(hold_flag_o), 32'd3);
      idle();
      chk("ih_halted", 32'(halted_o), 32'd0);
      chk("ih_hold2", 32'(hold_flag_o), 32'd3);
      idle();
      chk("ih_hold3", 32'(hold_flag_o), 32'd0);
      chk("ih_halted1", 32'(halted_o), 32'd0);

      // Debug halt during a flush
      drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("h_hold0", 32'(hold_flag_o), 32'd3);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("h_hold1", 32'(hold_flag_o), 32'd3);
      chk("h_halted0", 32'(halted_o), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("h_halted1", 32'(halted_o), 32'd1);
      chk("h_hold2", 32'(hold_flag_o), 32'd3);
      drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("h_jf_blk", 32'(jump_flag_o), 32'd0);
      chk("h_ja_blk", jump_addr_o, 32'd0);
      chk("h_hold3", 32'(hold_flag_o), 32'd3);
      idle();
      chk("h_rel_hold", 32'(hold_flag_o), 32'd3);
      chk("h_rel_halted", 32'(halted_o), 32'd1);
      idle();
      chk("h_idle_hold", 32'(hold_flag_o), 32'd0);
      chk("h_idle_halted", 32'(halted_o), 32'd0);
      chk("h_sc", stall_cycles_o, 32'd20);

      // Fresh reset before the watchdog run
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst2_sc", stall_cycles_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Watchdog: 20-cycle EX stall trips at the 16th stalled cycle
      for (int i = 1; i <= 20; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("wdt_to", 32'(stall_timeout_o), (i >= 17) ? 32'd1 : 32'd0);
      end
      idle();
      chk("wdt_sticky", 32'(stall_timeout_o), 32'd1);
      chk("wdt_sc", stall_cycles_o, 32'd20);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_lag", 32'(stall_timeout_o), 32'd1);
      idle();
      chk("clr_done", 32'(stall_timeout_o), 32'd0);

      // A 15-cycle stall never trips
      for (int i = 1; i <= 15; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("wdt15_to", 32'(stall_timeout_o), 32'd0);
      end
      idle();
      chk("wdt15_after", 32'(stall_timeout_o), 32'd0);
      idle();
      chk("wdt15_after2", 32'(stall_timeout_o), 32'd0);
      chk("wdt15_sc", stall_cycles_o, 32'd35);

      // Set and clear in the same cycle: set wins
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 16) ? 1'b1 : 1'b0);
      end
      idle();
      chk("set_wins", 32'(stall_timeout_o), 32'd1);
      chk("set_sc", stall_cycles_o, 32'd51);

      // Asynchronous reset mid-flush with the timeout flag set
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mr_hold0", 32'(hold_flag_o), 32'd3);
      idle();
      chk("mr_hold1", 32'(hold_flag_o), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_hold", 32'(hold_flag_o), 32'd0);
      chk("mr_to", 32'(stall_timeout_o), 32'd0);
      chk("mr_sc", stall_cycles_o, 32'd0);
      chk("mr_halted", 32'(halted_o), 32'd0);
      chk("mr_jf", 32'(jump_flag_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      chk("mr_post_hold", 32'(hold_flag_o), 32'd0);

      // Asynchronous reset while halted
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("hr_halted", 32'(halted_o), 32'd1);
      #2;
      halt_req_i = 1'b0;
      rst        = 1'b0;
      #1;
      chk("hr_halted0", 32'(halted_o), 32'd0);
      chk("hr_hold0", 32'(hold_flag_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      chk("hr_post_hold", 32'(hold_flag_o), 32'd0);
      chk("hr_post_halted", 32'(halted_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
